// File: rtl/memory_controller.sv
// Request sequencer for a bank of memory lines: accepts one read/write at a time,
// drives a one-cycle select/strobe to the addressed line and returns a response.
module memory_controller #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned LINES = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_write,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic [LINES-1:0]  o_mem_select,
    output logic              o_mem_wE,
    output logic              o_mem_rE,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                w_accept;
    logic [LINES-1:0]    w_onehot;
    logic [LINES-1:0]    r_mem_select;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_rdata;

    assign w_onehot = {{(LINES-1){1'b0}}, 1'b1} << i_req_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = i_req_write ? StWrite : StRead;
                end
            end
            StWrite, StRead: w_state_next = StResp;
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Strobes are loaded at acceptance so they are high exactly for the WRITE/READ cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_select <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_wdata      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_mem_select <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            if (w_accept) begin
                r_mem_select <= w_onehot;
                r_mem_we     <= i_req_write;
                r_mem_re     <= ~i_req_write;
                r_wdata      <= i_req_wdata;
            end
            if (r_state == StWrite) begin
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
            end
            if (r_state == StRead) begin
                r_rsp_write <= 1'b0;
                r_rsp_rdata <= i_mem_rdata;
            end
            r_rsp_valid <= (w_state_next == StResp);
        end
    end

    assign o_req_ready  = (r_state == StIdle);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_write  = r_rsp_write;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_mem_select = r_mem_select;
    assign o_mem_wE     = r_mem_we;
    assign o_mem_rE     = r_mem_re;
    assign o_mem_wdata  = r_wdata;

endmodule
